seq_bcd_seven_seg: RTL and testbench

//  Clocked, parametrised binary-to-seven-segment display engine for N-digit displays.

---
 rtl/seven_seg_pkg.sv | 59 +++++
 rtl/seg7_glyph_decoder.sv | 32 +++
 rtl/seq_bcd_seven_seg.sv | 131 +++++++++++++
 tb/tb_seq_bcd_seven_seg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the sequential binary-to-seven-segment display engine:
// active-high glyph constants, converter FSM states and sizing helpers.
package seven_seg_pkg;

  // Segment order a..g maps to bits 0..6; all constants are active-high.
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_A     = 7'h77;
  localparam logic [6:0] GLYPH_B     = 7'h7C;
  localparam logic [6:0] GLYPH_C     = 7'h39;
  localparam logic [6:0] GLYPH_D     = 7'h5E;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_F     = 7'h71;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  function automatic int count_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      4'hF:    g = GLYPH_F;
      default: g = GLYPH_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// One seven-segment digit: nibble to glyph with dash/blank override and
// optional inversion for common-anode displays.
module seg7_glyph_decoder
  import seven_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  logic [6:0] raw_s;

  // Dash (overflow) outranks blanking so an overflowed display is never partly dark.
  always_comb begin
    if (dash) begin
      raw_s = GLYPH_DASH;
    end else if (blank) begin
      raw_s = GLYPH_BLANK;
    end else begin
      raw_s = glyph(nibble);
    end
    if (ACTIVE_LOW != 0) begin
      seg = ~raw_s;
    end else begin
      seg = raw_s;
    end
  end

endmodule

// File: rtl/seq_bcd_seven_seg.sv
// Iterative double-dabble (or hex pass-through) converter feeding a latched
// N-digit seven-segment display with leading-zero blanking and overflow dashes.
module seq_bcd_seven_seg
  import seven_seg_pkg::*;
#(
  parameter int BIN_W      = 12,
  parameter int DIGITS     = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bcd_en,
  input  logic                  blank_lz,
  input  logic [BIN_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segments
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = count_width(BIN_W);
  localparam int EXT_W = (BIN_W > BCD_W) ? BIN_W : BCD_W;

  conv_state_t       state_r;
  logic [SR_W-1:0]   sr_r;
  logic [SR_W-1:0]   adj_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              ovf_r;
  logic [BCD_W-1:0]  digit_r;
  logic [EXT_W-1:0]  val_ext_s;
  logic [BCD_W-1:0]  hex_nib_s;
  logic              hex_ovf_s;
  logic [DIGITS-1:0] blank_s;
  logic              zero_run_s;

  // Hex nibbles/overflow from the raw input and the +3 correction of every BCD nibble.
  always_comb begin
    val_ext_s = EXT_W'(value);
    hex_nib_s = val_ext_s[BCD_W-1:0];
    hex_ovf_s = ((val_ext_s >> BCD_W) != {EXT_W{1'b0}});
    adj_s     = sr_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_r[BIN_W+4*i +: 4] >= 4'd5) begin
        adj_s[BIN_W+4*i +: 4] = sr_r[BIN_W+4*i +: 4] + 4'd3;
      end else begin
        adj_s[BIN_W+4*i +: 4] = sr_r[BIN_W+4*i +: 4];
      end
    end
  end

  // Converter FSM; hex mode preloads its nibbles into the BCD half so LOAD is shared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sr_r     <= {SR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
      digit_r  <= {BCD_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt_r <= {CNT_W{1'b0}};
            if (bcd_en) begin
              sr_r    <= {{BCD_W{1'b0}}, value};
              ovf_r   <= 1'b0;
              state_r <= SHIFT;
            end else begin
              sr_r    <= {hex_nib_s, {BIN_W{1'b0}}};
              ovf_r   <= hex_ovf_s;
              state_r <= LOAD;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          sr_r  <= {adj_s[SR_W-2:0], 1'b0};
          ovf_r <= ovf_r | adj_s[SR_W-1];
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(BIN_W - 1)) begin
            state_r <= LOAD;
          end else begin
            state_r <= SHIFT;
          end
        end
        LOAD: begin
          digit_r  <= sr_r[SR_W-1:BIN_W];
          overflow <= ovf_r;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // A digit blanks only if it and everything above it is zero; digit 0 always shows.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (digit_r[4*i +: 4] == 4'd0);
      blank_s[i] = blank_lz & zero_run_s & (i != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
    seg7_glyph_decoder #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_dec (
      .nibble(digit_r[4*g +: 4]),
      .blank (blank_s[g]),
      .dash  (overflow),
      .seg   (segments[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_seq_bcd_seven_seg.sv
// Scoreboard bench: a 4-digit common-anode instance and a 3-digit active-high
// instance; expected displays are queued at start and checked on each done.
module tb_seq_bcd_seven_seg;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S9 = 7'h6F, SA = 7'h77, SB = 7'h7C, SC = 7'h39;
  localparam logic [6:0] SD = 7'h40, SX = 7'h00;

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
    int          cyc;
    string       nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0, bcd1 = 1'b0, blz1 = 1'b0;
  logic start3 = 1'b0, bcd3 = 1'b0, blz3 = 1'b0;
  logic [11:0] value1 = 12'd0, value3 = 12'd0;
  logic busy1, done1, ovf1, busy3, done3, ovf3;
  logic [27:0] seg1;
  logic [20:0] seg3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t m1_e, m3_e;

  seq_bcd_seven_seg #(.BIN_W(12), .DIGITS(4), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bcd_en(bcd1), .blank_lz(blz1),
    .value(value1), .busy(busy1), .done(done1), .overflow(ovf1), .segments(seg1)
  );

  seq_bcd_seven_seg #(.BIN_W(12), .DIGITS(3), .ACTIVE_LOW(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .bcd_en(bcd3), .blank_lz(blz3),
    .value(value3), .busy(busy3), .done(done3), .overflow(ovf3), .segments(seg3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        m1_e = q1.pop_front();
        chk({m1_e.nm, "_seg"}, {4'd0, seg1}, {4'd0, m1_e.seg});
        chk({m1_e.nm, "_ovf"}, {31'd0, ovf1}, {31'd0, m1_e.ovf});
        chk({m1_e.nm, "_latency"}, cyc, m1_e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done3 === 1'b1) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        m3_e = q3.pop_front();
        chk({m3_e.nm, "_seg"}, {11'd0, seg3}, {4'd0, m3_e.seg});
        chk({m3_e.nm, "_ovf"}, {31'd0, ovf3}, {31'd0, m3_e.ovf});
        chk({m3_e.nm, "_latency"}, cyc, m3_e.cyc);
      end
    end
  end

  task automatic issue(input bit on3, input logic bcd, input logic [11:0] v, input logic blz,
                       input logic [27:0] eseg, input logic eovf, input bit push,
                       input string nm);
    exp_t e;
    @(negedge clk);
    if (on3) begin
      start3 = 1'b1; bcd3 = bcd; value3 = v; blz3 = blz;
    end else begin
      start1 = 1'b1; bcd1 = bcd; value1 = v; blz1 = blz;
    end
    e.seg = eseg;
    e.ovf = eovf;
    e.cyc = cyc + 1 + (bcd ? 13 : 1);
    e.nm  = nm;
    if (push) begin
      if (on3) q3.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 60 && (q1.size() != 0 || q3.size() != 0); k++) @(posedge clk);
    if (q1.size() != 0 || q3.size() != 0) begin
      chk({nm, "_done_timeout"}, q1.size() + q3.size(), 32'd0);
      q1.delete();
      q3.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_seg1", {4'd0, seg1}, {4'd0, ~{S0, S0, S0, S0}});
    chk("reset_seg3", {11'd0, seg3}, {11'd0, S0, S0, S0});
    chk("reset_busy", {31'd0, busy1}, 32'd0);
    chk("reset_done", {31'd0, done1}, 32'd0);
    chk("reset_ovf", {31'd0, ovf1}, 32'd0);

    issue(1'b0, 1'b1, 12'd255, 1'b0, ~{S0, S2, S5, S5}, 1'b0, 1'b1, "bcd255");
    wait_drain("bcd255");
    issue(1'b0, 1'b1, 12'd255, 1'b1, ~{SX, S2, S5, S5}, 1'b0, 1'b1, "bcd255_blank");
    wait_drain("bcd255_blank");
    blz1 = 1'b0;
    #1 chk("live_unblank", {4'd0, seg1}, {4'd0, ~{S0, S2, S5, S5}});
    issue(1'b0, 1'b1, 12'd0, 1'b1, ~{SX, SX, SX, S0}, 1'b0, 1'b1, "bcd0_blank");
    wait_drain("bcd0_blank");
    issue(1'b0, 1'b0, 12'hABC, 1'b0, ~{S0, SA, SB, SC}, 1'b0, 1'b1, "hexabc");
    wait_drain("hexabc");

    issue(1'b0, 1'b1, 12'd1234, 1'b0, ~{S1, S2, S3, S4}, 1'b0, 1'b1, "bcd1234");
    repeat (3) @(negedge clk);
    chk("busy_mid", {31'd0, busy1}, 32'd1);
    chk("hold_mid", {4'd0, seg1}, {4'd0, ~{S0, SA, SB, SC}});
    start1 = 1'b1; bcd1 = 1'b1; value1 = 12'd7;
    @(negedge clk);
    start1 = 1'b0;
    wait_drain("bcd1234");
    repeat (20) @(negedge clk);
    chk("ignored_start_seg", {4'd0, seg1}, {4'd0, ~{S1, S2, S3, S4}});

    issue(1'b1, 1'b1, 12'd1000, 1'b0, {7'd0, SD, SD, SD}, 1'b1, 1'b1, "d3_bcd1000");
    wait_drain("d3_bcd1000");
    issue(1'b1, 1'b1, 12'd999, 1'b1, {7'd0, S9, S9, S9}, 1'b0, 1'b1, "d3_bcd999");
    wait_drain("d3_bcd999");
    issue(1'b1, 1'b0, 12'hABC, 1'b0, {7'd0, SA, SB, SC}, 1'b0, 1'b1, "d3_hexabc");
    wait_drain("d3_hexabc");

    issue(1'b0, 1'b1, 12'd999, 1'b0, 28'd0, 1'b0, 1'b0, "abort");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_done", {31'd0, done1}, 32'd0);
    chk("abort_seg", {4'd0, seg1}, {4'd0, ~{S0, S0, S0, S0}});
    chk("abort_ovf", {31'd0, ovf1}, 32'd0);
    chk("abort_seg3", {11'd0, seg3}, {11'd0, S0, S0, S0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_quiet_seg", {4'd0, seg1}, {4'd0, ~{S0, S0, S0, S0}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
